// File: rtl/v_pkg.sv
// Shared types for the SRAM scan checker.
// Scan FSM state encoding is one-hot so each state bit doubles as a
// direct decode for the corresponding output/phase.
package v_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ISSUE = 4'b0010,
    S_DRAIN = 4'b0100,
    S_DONE  = 4'b1000
  } v_scan_state_t;

endpackage

// File: rtl/v_scan_pipe.sv
// Read-tracking delay line for v_scan.
// Follows each accepted SRAM read through RD_LAT stages so its address
// emerges on the same cycle as the returned data.
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears valids only)
//   flush      synchronous kill of every in-flight read
//   acc        a read was accepted this cycle
//   acc_addr   address of that read
//   out_vld    returned data on i_scan_rdata belongs to a tracked read
//   out_addr   address of that read
//   pending    a read is still in flight behind the output stage
module v_scan_pipe #(
  parameter int RD_LAT = 1,
  parameter int AW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          acc,
  input  logic [AW-1:0] acc_addr,
  output logic          out_vld,
  output logic [AW-1:0] out_addr,
  output logic          pending
);

  localparam logic [RD_LAT-1:0] LAST_MASK = RD_LAT'(1) << (RD_LAT - 1);

  logic [RD_LAT-1:0] vld_p;
  logic [AW-1:0]     addr_p [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= acc;
      for (int k = 1; k < RD_LAT; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    addr_p[0] <= acc_addr;
    for (int k = 1; k < RD_LAT; k++) addr_p[k] <= addr_p[k-1];
  end

  assign out_vld  = vld_p[RD_LAT-1];
  assign out_addr = addr_p[RD_LAT-1];
  // The output stage is being compared this cycle, so it does not count
  // as outstanding work when deciding whether the drain can finish.
  assign pending  = |(vld_p & ~LAST_MASK);

endmodule

// File: rtl/v_scan.sv
// SRAM read-side scan checker.
// Sweeps all N words through a shared, arbitrated read port and compares
// each returned word with a latched expected value. Reports pass/fail,
// mismatch count and first mismatching address.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   o_scan_ren_r      read request (held until granted)
//   o_scan_raddr_r    read address
//   i_scan_rgnt       read accepted this cycle
//   i_scan_rdata      read data, RD_LAT cycles after accept
//   i_start           start/restart pulse, i_expect sampled with it
//   o_busy_r          scan in progress (ISSUE/DRAIN)
//   o_done_r          one-cycle completion pulse
//   o_pass_r          no mismatches in the last completed scan
//   o_err_cnt_r       mismatch count
//   o_err_addr_r      first mismatching address (0 if none)
module v_scan
  import v_pkg::*;
#(
  parameter int N      = 16,
  parameter int W      = 32,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   o_scan_ren_r,
  output logic [$clog2(N)-1:0]   o_scan_raddr_r,
  input  logic                   i_scan_rgnt,
  input  logic [W-1:0]           i_scan_rdata,
  input  logic                   i_start,
  input  logic [W-1:0]           i_expect,
  output logic                   o_busy_r,
  output logic                   o_done_r,
  output logic                   o_pass_r,
  output logic [$clog2(N+1)-1:0] o_err_cnt_r,
  output logic [$clog2(N)-1:0]   o_err_addr_r
);

  localparam int AW = $clog2(N);
  localparam int CW = $clog2(N+1);

  v_scan_state_t state, state_nxt;
  logic [W-1:0]  expect_q;
  logic          acc, last_acc;
  logic          out_vld, pending, cmp_err;
  logic [AW-1:0] out_addr;

  assign o_scan_ren_r = (state == S_ISSUE);
  assign o_busy_r     = (state == S_ISSUE) || (state == S_DRAIN);
  assign o_done_r     = (state == S_DONE);

  assign acc      = o_scan_ren_r && i_scan_rgnt;
  assign last_acc = acc && (o_scan_raddr_r == AW'(N - 1));

  // Issue -> return boundary: accepted reads tracked until data emerges.
  v_scan_pipe #(.RD_LAT(RD_LAT), .AW(AW)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .flush    (i_start),
    .acc      (acc),
    .acc_addr (o_scan_raddr_r),
    .out_vld  (out_vld),
    .out_addr (out_addr),
    .pending  (pending)
  );

  // Return -> compare boundary.
  assign cmp_err = out_vld && (i_scan_rdata != expect_q);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_IDLE;
      S_ISSUE: if (last_acc) state_nxt = S_DRAIN;
      S_DRAIN: if (!pending) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (i_start) state_nxt = S_ISSUE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      o_scan_raddr_r <= '0;
      o_err_cnt_r    <= '0;
      o_err_addr_r   <= '0;
      o_pass_r       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (i_start) begin
        o_scan_raddr_r <= '0;
        o_err_cnt_r    <= '0;
        o_err_addr_r   <= '0;
        o_pass_r       <= 1'b0;
      end else begin
        // Address parks on N-1 after the final accept.
        if (acc && !last_acc) o_scan_raddr_r <= o_scan_raddr_r + AW'(1);
        if (cmp_err) begin
          o_err_cnt_r <= o_err_cnt_r + CW'(1);
          if (o_err_cnt_r == '0) o_err_addr_r <= out_addr;
        end
        // The final compare may land on the same edge as entry to DONE,
        // so pass must account for it to be valid during the done pulse.
        if (state_nxt == S_DONE) o_pass_r <= (o_err_cnt_r == '0) && !cmp_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_start) expect_q <= i_expect;
  end

endmodule

// File: tb/tb_v_scan.sv
module tb_v_scan;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: N=8, W=8, RD_LAT=1
  logic       ren_a, gnt_a, start_a, busy_a, done_a, pass_a;
  logic [2:0] raddr_a, erra_a;
  logic [3:0] errc_a;
  logic [7:0] rdata_a, expect_a;
  logic [7:0] mem_a [8];

  // DUT B: N=5, W=8, RD_LAT=3
  logic       ren_b, gnt_b, start_b, busy_b, done_b, pass_b;
  logic [2:0] raddr_b, erra_b;
  logic [2:0] errc_b;
  logic [7:0] expect_b;
  logic [7:0] mem_b [8];
  logic [7:0] dq_b [3];

  int n_tests = 0;
  int n_fail  = 0;

  // observations from run_a
  int   acc_n, done_n, done_cyc, busy_n, first_busy, last_busy;
  bit   seq_ok, ren_extra;
  logic       pass_d;
  logic [3:0] cnt_d;
  logic [2:0] ea_d;

  v_scan #(.N(8), .W(8), .RD_LAT(1)) u_a (
    .clk(clk), .rst(rst),
    .o_scan_ren_r(ren_a), .o_scan_raddr_r(raddr_a),
    .i_scan_rgnt(gnt_a), .i_scan_rdata(rdata_a),
    .i_start(start_a), .i_expect(expect_a),
    .o_busy_r(busy_a), .o_done_r(done_a), .o_pass_r(pass_a),
    .o_err_cnt_r(errc_a), .o_err_addr_r(erra_a)
  );

  v_scan #(.N(5), .W(8), .RD_LAT(3)) u_b (
    .clk(clk), .rst(rst),
    .o_scan_ren_r(ren_b), .o_scan_raddr_r(raddr_b),
    .i_scan_rgnt(gnt_b), .i_scan_rdata(dq_b[2]),
    .i_start(start_b), .i_expect(expect_b),
    .o_busy_r(busy_b), .o_done_r(done_b), .o_pass_r(pass_b),
    .o_err_cnt_r(errc_b), .o_err_addr_r(erra_b)
  );

  // SRAM models. Idle cycles return 0xEE; a read accepted on a restart
  // cycle returns 0xFF so a counted stale return shows up as an error.
  always @(posedge clk) begin
    if (ren_a && gnt_a) rdata_a <= start_a ? 8'hFF : mem_a[raddr_a];
    else                rdata_a <= 8'hEE;
  end

  always @(posedge clk) begin
    dq_b[0] <= (ren_b && gnt_b) ? mem_b[raddr_b] : 8'hEE;
    dq_b[1] <= dq_b[0];
    dq_b[2] <= dq_b[1];
  end

  task automatic clear_mem_a;
    for (int i = 0; i < 8; i++) mem_a[i] = 8'h00;
  endtask

  task automatic run_a(input int gnt_mode, input int restart_addr);
    int  exp_addr, kbase;
    bit  restarted;
    acc_n = 0; done_n = 0; done_cyc = -1; busy_n = 0;
    first_busy = -1; last_busy = -1; seq_ok = 1; ren_extra = 0;
    pass_d = 1'bx; cnt_d = 'x; ea_d = 'x;
    exp_addr = 0; kbase = 0; restarted = 0;
    @(negedge clk);
    start_a = 1'b1; expect_a = 8'h00; gnt_a = (gnt_mode == 0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (ren_a) begin
        if (acc_n >= 8) ren_extra = 1;
        if (raddr_a !== exp_addr[2:0]) seq_ok = 0;
      end
      if (busy_a) begin
        busy_n++;
        if (first_busy < 0) first_busy = k - kbase;
        last_busy = k - kbase;
      end
      if (done_a) begin
        done_n++; done_cyc = k - kbase;
        pass_d = pass_a; cnt_d = errc_a; ea_d = erra_a;
      end
      gnt_a = (gnt_mode == 0) ? 1'b1 : (k % 2 == 0);
      if (restart_addr >= 0 && !restarted && ren_a && raddr_a == restart_addr[2:0]) begin
        start_a = 1'b1; restarted = 1; kbase = k; exp_addr = 0;
        acc_n = 0; busy_n = 0; first_busy = -1;
      end else if (ren_a && gnt_a) begin
        acc_n++; exp_addr++;
      end
    end
    gnt_a = 1'b0;
  endtask

  task automatic test_reset;
    n_tests++;
    if ({ren_a, busy_a, done_a, pass_a, errc_a, erra_a, raddr_a} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_a: outputs %b, want all 0", {ren_a, busy_a, done_a, pass_a, errc_a, erra_a, raddr_a});
    end
    n_tests++;
    if ({ren_b, busy_b, done_b, pass_b, errc_b, erra_b, raddr_b} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_b: outputs %b, want all 0", {ren_b, busy_b, done_b, pass_b, errc_b, erra_b, raddr_b});
    end
  endtask

  task automatic test_clean_scan;
    clear_mem_a();
    run_a(0, -1);
    n_tests++; if (acc_n !== 8) begin n_fail++; $display("FAIL clean_accepts: got %0d, want 8", acc_n); end
    n_tests++; if (seq_ok !== 1'b1) begin n_fail++; $display("FAIL clean_addr_seq: got %0d, want 1", seq_ok); end
    n_tests++; if (ren_extra !== 1'b0) begin n_fail++; $display("FAIL clean_ren_drop: got %0d, want 0", ren_extra); end
    n_tests++; if (done_n !== 1) begin n_fail++; $display("FAIL clean_done_count: got %0d, want 1", done_n); end
    n_tests++; if (done_cyc !== 10) begin n_fail++; $display("FAIL clean_done_cycle: got %0d, want 10", done_cyc); end
    n_tests++; if (first_busy !== 1 || last_busy !== 9 || busy_n !== 9) begin
      n_fail++; $display("FAIL clean_busy: got %0d..%0d n=%0d, want 1..9 n=9", first_busy, last_busy, busy_n);
    end
    n_tests++; if (pass_d !== 1'b1) begin n_fail++; $display("FAIL clean_pass: got %b, want 1", pass_d); end
    n_tests++; if (cnt_d !== 4'd0) begin n_fail++; $display("FAIL clean_err_cnt: got %0d, want 0", cnt_d); end
    n_tests++; if (pass_a !== 1'b1) begin n_fail++; $display("FAIL clean_pass_held: got %b, want 1", pass_a); end
  endtask

  task automatic test_mismatch;
    clear_mem_a();
    mem_a[3] = 8'h5A; mem_a[6] = 8'h01;
    run_a(0, -1);
    n_tests++; if (done_cyc !== 10) begin n_fail++; $display("FAIL mis_done_cycle: got %0d, want 10", done_cyc); end
    n_tests++; if (pass_d !== 1'b0) begin n_fail++; $display("FAIL mis_pass: got %b, want 0", pass_d); end
    n_tests++; if (cnt_d !== 4'd2) begin n_fail++; $display("FAIL mis_err_cnt: got %0d, want 2", cnt_d); end
    n_tests++; if (ea_d !== 3'd3) begin n_fail++; $display("FAIL mis_err_addr: got %0d, want 3", ea_d); end
    n_tests++; if (errc_a !== 4'd2 || erra_a !== 3'd3) begin
      n_fail++; $display("FAIL mis_held: got cnt=%0d addr=%0d, want 2/3", errc_a, erra_a);
    end
  endtask

  task automatic test_gnt_stall;
    clear_mem_a();
    run_a(1, -1);
    n_tests++; if (acc_n !== 8) begin n_fail++; $display("FAIL stall_accepts: got %0d, want 8", acc_n); end
    n_tests++; if (seq_ok !== 1'b1) begin n_fail++; $display("FAIL stall_addr_hold: got %0d, want 1", seq_ok); end
    n_tests++; if (done_n !== 1 || done_cyc !== 18) begin
      n_fail++; $display("FAIL stall_done: got n=%0d cyc=%0d, want 1/18", done_n, done_cyc);
    end
    n_tests++; if (pass_d !== 1'b1 || cnt_d !== 4'd0) begin
      n_fail++; $display("FAIL stall_result: got pass=%b cnt=%0d, want 1/0", pass_d, cnt_d);
    end
  endtask

  task automatic test_restart;
    clear_mem_a();
    run_a(0, 4);
    n_tests++; if (seq_ok !== 1'b1) begin n_fail++; $display("FAIL restart_addr_seq: got %0d, want 1", seq_ok); end
    n_tests++; if (acc_n !== 8) begin n_fail++; $display("FAIL restart_accepts: got %0d, want 8", acc_n); end
    n_tests++; if (done_n !== 1 || done_cyc !== 10) begin
      n_fail++; $display("FAIL restart_done: got n=%0d cyc=%0d, want 1/10", done_n, done_cyc);
    end
    n_tests++; if (pass_d !== 1'b1 || cnt_d !== 4'd0) begin
      n_fail++; $display("FAIL restart_stale: got pass=%b cnt=%0d, want 1/0", pass_d, cnt_d);
    end
  endtask

  task automatic test_rst_drain;
    int dn;
    clear_mem_a();
    mem_a[2] = 8'h11;
    @(negedge clk);
    start_a = 1'b1; expect_a = 8'h00; gnt_a = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    // cycle t+9: DRAIN with one error already counted
    n_tests++; if (busy_a !== 1'b1 || ren_a !== 1'b0 || errc_a !== 4'd1) begin
      n_fail++; $display("FAIL rst_pre: got busy=%b ren=%b cnt=%0d, want 1/0/1", busy_a, ren_a, errc_a);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; gnt_a = 1'b0;
    n_tests++;
    if ({ren_a, busy_a, done_a, pass_a, errc_a, erra_a, raddr_a} !== 15'd0) begin
      n_fail++; $display("FAIL rst_drain: outputs %b, want all 0", {ren_a, busy_a, done_a, pass_a, errc_a, erra_a, raddr_a});
    end
    dn = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done_a) dn++;
    end
    n_tests++; if (dn !== 0) begin n_fail++; $display("FAIL rst_no_done: got %0d, want 0", dn); end
    mem_a[2] = 8'h00;
    run_a(0, -1);
    n_tests++; if (done_cyc !== 10 || pass_d !== 1'b1) begin
      n_fail++; $display("FAIL rst_rescan: got cyc=%0d pass=%b, want 10/1", done_cyc, pass_d);
    end
  endtask

  task automatic test_lat3;
    int acc, dcyc, dn;
    logic [2:0] last;
    logic [2:0] cnt, ea;
    logic pd;
    for (int i = 0; i < 8; i++) mem_b[i] = 8'h00;
    mem_b[4] = 8'hFF;
    acc = 0; dcyc = -1; dn = 0; last = '0; cnt = 'x; ea = 'x; pd = 1'bx;
    @(negedge clk);
    start_b = 1'b1; expect_b = 8'h00; gnt_b = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (ren_b) begin acc++; last = raddr_b; end
      if (done_b) begin dn++; dcyc = k; cnt = errc_b; ea = erra_b; pd = pass_b; end
    end
    gnt_b = 1'b0;
    n_tests++; if (acc !== 5 || last !== 3'd4) begin
      n_fail++; $display("FAIL lat3_accepts: got n=%0d last=%0d, want 5/4", acc, last);
    end
    n_tests++; if (dn !== 1 || dcyc !== 9) begin
      n_fail++; $display("FAIL lat3_done: got n=%0d cyc=%0d, want 1/9", dn, dcyc);
    end
    n_tests++; if (cnt !== 3'd1 || ea !== 3'd4 || pd !== 1'b0) begin
      n_fail++; $display("FAIL lat3_result: got cnt=%0d addr=%0d pass=%b, want 1/4/0", cnt, ea, pd);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; gnt_a = 1'b0; expect_a = 8'h00;
    start_b = 1'b0; gnt_b = 1'b0; expect_b = 8'h00;
    for (int i = 0; i < 8; i++) begin mem_a[i] = 8'h00; mem_b[i] = 8'h00; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_scan();
    test_mismatch();
    test_gnt_stall();
    test_restart();
    test_rst_drain();
    test_lat3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
